neopixel_strand_driver: RTL and testbench

// - Parametrised successor strand controller: holds a GRB colour frame for NUM_PIXELS LEDs and,
//   on request, emits the full frame as a timed WS2812 serial waveform followed by a latch gap.
// - Sits between the host/load logic and the strand data pin; one instance per strand.

---
 rtl/neopixel_pkg.sv | 19 +
 rtl/neopixel_bit_timer.sv | 67 ++++++
 rtl/neopixel_strand_driver.sv | 132 +++++++++++++
 tb/tb_neopixel_strand_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared types for the WS2812 strand driver.
// Colour channel codes, controller states and frame geometry.
package neopixel_pkg;

  typedef enum logic [1:0] {
    CI_RED   = 2'b00,
    CI_BLUE  = 2'b01,
    CI_GREEN = 2'b10
  } color_index_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    LATCH
  } state_t;

  localparam int BITS_PER_PIXEL = 24;

endpackage

// File: rtl/neopixel_bit_timer.sv
// One WS2812 bit period: high for T0H/T1H clocks, low for the rest.
// bit_done marks the last clock of the period so a new bit can start seamlessly.
module neopixel_bit_timer #(
  parameter int T0H   = 18,
  parameter int T1H   = 35,
  parameter int T_BIT = 63
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic bit_val,
  output logic neo_data,
  output logic bit_done
);

  localparam int CW = $clog2(T_BIT);
  localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] H0 = CW'(T0H);
  localparam logic [CW-1:0] H1 = CW'(T1H);

  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic act_q, act_d;
  logic one_q, one_d;
  logic hi_q, hi_d;

  assign cnt_nx   = cnt_q + CW'(1);
  assign bit_done = act_q && (cnt_q == LAST);
  assign neo_data = hi_q;

  // hi_d looks one clock ahead so neo_data leaves a flop
  always_comb begin
    cnt_d = cnt_q;
    act_d = act_q;
    one_d = one_q;
    hi_d  = hi_q;
    if (start) begin
      cnt_d = '0;
      act_d = 1'b1;
      one_d = bit_val;
      hi_d  = 1'b1;
    end else if (act_q) begin
      if (bit_done) begin
        cnt_d = '0;
        act_d = 1'b0;
        hi_d  = 1'b0;
      end else begin
        cnt_d = cnt_nx;
        hi_d  = cnt_nx < (one_q ? H1 : H0);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      act_q <= 1'b0;
      one_q <= 1'b0;
      hi_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      one_q <= one_d;
      hi_q  <= hi_d;
    end
  end

endmodule

// File: rtl/neopixel_strand_driver.sv
// WS2812 strand controller: GRB colour store, frame sequencer and latch gap.
// Pixel 0 goes out first, each pixel as G[7:0], R[7:0], B[7:0].
module neopixel_strand_driver
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS = 5,
  parameter int T0H        = 18,
  parameter int T1H        = 35,
  parameter int T_BIT      = 63,
  parameter int T_LATCH    = 2600,
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [7:0]    color_level,
  input  logic [1:0]    color_index,
  input  logic [PW-1:0] pixel_index,
  input  logic          load_color,
  input  logic          send_it,
  output logic          neo_data,
  output logic          ready_to_load,
  output logic          ready_to_send,
  output logic          frame_done
);

  localparam int LW = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;
  localparam logic [4:0] LAST_BIT = 5'(BITS_PER_PIXEL - 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIXELS - 1);
  localparam logic [LW-1:0] LAST_LAT = LW'(T_LATCH - 1);

  state_t state_q, state_d;
  logic [NUM_PIXELS-1:0][23:0] px_q, px_d;
  logic [4:0] bit_q, bit_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] lat_q, lat_d;
  logic ready_q, ready_d;
  logic done_q, done_d;
  logic start, bit_val, bit_done;
  logic [23:0] word;

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    lat_d   = lat_q;
    start   = 1'b0;
    if (state_q == IDLE && load_color && 32'(pixel_index) < NUM_PIXELS) begin
      case (color_index)
        CI_RED:   px_d[pixel_index][15:8]  = color_level;
        CI_BLUE:  px_d[pixel_index][7:0]   = color_level;
        CI_GREEN: px_d[pixel_index][23:16] = color_level;
        default:  px_d = px_q;
      endcase
    end
    case (state_q)
      IDLE: begin
        if (send_it) begin
          state_d = SEND;
          bit_d   = '0;
          pix_d   = '0;
          start   = 1'b1;
        end
      end
      SEND: begin
        if (bit_done) begin
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (pix_q == LAST_PIX) begin
              state_d = LATCH;
              lat_d   = '0;
            end else begin
              pix_d = pix_q + PW'(1);
              start = 1'b1;
            end
          end else begin
            bit_d = bit_q + 5'd1;
            start = 1'b1;
          end
        end
      end
      LATCH: begin
        if (lat_q == LAST_LAT) state_d = IDLE;
        else lat_d = lat_q + LW'(1);
      end
      default: state_d = IDLE;
    endcase
    // px_d so a same-cycle load lands in the frame being started
    word    = px_d[pix_d];
    bit_val = word[LAST_BIT - bit_d];
    done_d  = (state_d == LATCH) && (lat_d == LAST_LAT);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      px_q    <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      lat_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      lat_q   <= lat_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  neopixel_bit_timer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .T_BIT(T_BIT)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bit_val (bit_val),
    .neo_data(neo_data),
    .bit_done(bit_done)
  );

  assign ready_to_load = ready_q;
  assign ready_to_send = ready_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_neopixel_strand_driver.sv
// Bench for neopixel_strand_driver: expected high widths are queued per frame
// from a colour model and compared as each bit period is decoded.
module tb_neopixel_strand_driver;

  localparam int N       = 5;
  localparam int T0H     = 18;
  localparam int T1H     = 35;
  localparam int T_BIT   = 63;
  localparam int T_LATCH = 2600;

  logic       clock;
  logic       reset_n;
  logic [7:0] color_level;
  logic [1:0] color_index;
  logic [2:0] pixel_index;
  logic       load_color;
  logic       send_it;
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;
  logic       frame_done;

  neopixel_strand_driver #(
    .NUM_PIXELS(N),
    .T0H       (T0H),
    .T1H       (T1H),
    .T_BIT     (T_BIT),
    .T_LATCH   (T_LATCH)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .color_level  (color_level),
    .color_index  (color_index),
    .pixel_index  (pixel_index),
    .load_color   (load_color),
    .send_it      (send_it),
    .neo_data     (neo_data),
    .ready_to_load(ready_to_load),
    .ready_to_send(ready_to_send),
    .frame_done   (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  int bad;
  int bit_no;
  int q[$];
  logic [23:0] m[N];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_load(input int p, input int ci, input logic [7:0] v);
    if (p < N) begin
      case (ci)
        0: m[p][15:8]  = v;
        1: m[p][7:0]   = v;
        2: m[p][23:16] = v;
        default: ;
      endcase
    end
  endtask

  task automatic set_pins(input int p, input int ci, input logic [7:0] v);
    pixel_index = 3'(p);
    color_index = 2'(ci);
    color_level = v;
    load_color  = 1'b1;
  endtask

  task automatic idle_load(input int p, input int ci, input logic [7:0] v);
    model_load(p, ci, v);
    set_pins(p, ci, v);
    @(negedge clock);
    load_color = 1'b0;
  endtask

  task automatic push_frame();
    for (int p = 0; p < N; p++)
      for (int b = 23; b >= 0; b--)
        q.push_back(m[p][b] ? T1H : T0H);
  endtask

  task automatic start_frame(input bit hold);
    push_frame();
    bad = 0;
    bit_no = 0;
    send_it = 1'b1;
    @(negedge clock);
    if (!hold) send_it = 1'b0;
  endtask

  task automatic capture_bits(input int n);
    for (int i = 0; i < n; i++) begin
      int ones;
      int exp;
      ones = 0;
      exp = (q.size() > 0) ? q.pop_front() : -1;
      for (int c = 0; c < T_BIT; c++) begin
        if (c == 0 && !neo_data) bad++;
        if (frame_done || ready_to_load || ready_to_send) bad++;
        ones += int'(neo_data);
        @(negedge clock);
      end
      check($sformatf("bit%0d", bit_no), ones, exp);
      bit_no++;
    end
  endtask

  task automatic finish_frame();
    int lat;
    lat = 0;
    while (!frame_done && lat < T_LATCH + 8) begin
      if (neo_data || ready_to_load || ready_to_send) bad++;
      lat++;
      @(negedge clock);
    end
    if (neo_data || ready_to_send) bad++;
    check("frame_done", frame_done, 1);
    check("latch_len", lat + 1, T_LATCH);
    check("frame_status", bad, 0);
    check("queue_left", q.size(), 0);
    @(negedge clock);
    check("ready_idle", ready_to_load && ready_to_send, 1);
    check("done_pulse", frame_done, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    color_level = '0;
    color_index = '0;
    pixel_index = '0;
    load_color = 1'b0;
    send_it = 1'b0;
    for (int p = 0; p < N; p++) m[p] = '0;
    repeat (3) @(negedge clock);
    check("rst_neo", neo_data, 0);
    check("rst_rdy_load", ready_to_load, 1);
    check("rst_rdy_send", ready_to_send, 1);
    check("rst_done", frame_done, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // all-zero frame after reset
    start_frame(1'b0);
    capture_bits(24 * N);
    finish_frame();

    // pixel data, reserved channel and out-of-range pixel
    idle_load(0, 2, 8'h80);
    idle_load(0, 0, 8'h01);
    idle_load(0, 1, 8'h00);
    idle_load(3, 2, 8'h5A);
    idle_load(1, 1, 8'hC3);
    idle_load(1, 3, 8'hFF);
    idle_load(7, 0, 8'hFF);
    start_frame(1'b0);
    capture_bits(10);
    set_pins(2, 0, 8'hFF);
    capture_bits(1);
    load_color = 1'b0;
    capture_bits(24 * N - 11);
    finish_frame();

    // same-cycle load and send, send held for back-to-back
    model_load(4, 1, 8'hAA);
    set_pins(4, 1, 8'hAA);
    start_frame(1'b1);
    load_color = 1'b0;
    capture_bits(24 * N);
    finish_frame();
    start_frame(1'b0);
    capture_bits(24 * N);
    finish_frame();

    // reset in the middle of a frame
    start_frame(1'b0);
    capture_bits(50);
    check("pre_rst_high", neo_data, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_neo", neo_data, 0);
    check("mid_rst_rdy", ready_to_send, 1);
    q.delete();
    for (int p = 0; p < N; p++) m[p] = '0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (frame_done || neo_data) bad++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (frame_done || neo_data || !ready_to_load) bad++;
    end
    check("post_rst_quiet", bad, 0);

    start_frame(1'b0);
    capture_bits(24 * N);
    finish_frame();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
